// File: rtl/mem_ctrl_pkg.sv
// Shared defines for the CPU memory path: controller states, access size codes, I/O region tag.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } mc_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } mc_owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating IF/LS; read done n+1 cycles and write done n cycles after accept.
// rdy_in low freezes progress; I/O-region write bytes wait while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_clear,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_e   state_q, state_d;
  mc_owner_e   own_q, own_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  // cnt_q counts finished bytes; pend_q marks a read byte whose data is on mem_din now
  logic [2:0]  pres_idx;
  logic [31:0] pres_addr;
  logic [31:0] cap_word;
  logic        io_block;

  assign pres_idx  = cnt_q + {2'b00, pend_q};
  assign pres_addr = addr_q + {29'd0, pres_idx};
  assign cap_word  = rbuf_q | ({24'd0, mem_din} << {cnt_q[1:0], 3'b000});
  assign io_block  = (pres_addr[17:16] == IO_HI) && io_buffer_full;

  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    rbuf_d     = rbuf_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    mem_a      = 32'd0;
    mem_dout   = 8'd0;
    mem_wr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rdy_in && (ls_req || (if_req && !if_clear))) begin
          cnt_d  = 3'd0;
          pend_d = 1'b0;
          rbuf_d = 32'd0;
          if (ls_req) begin
            own_d    = OWN_LS;
            addr_d   = ls_addr;
            wdata_d  = ls_wdata;
            nbytes_d = size_bytes(ls_size);
            state_d  = ls_we ? ST_WRITE : ST_READ;
          end else begin
            own_d    = OWN_IF;
            addr_d   = if_addr;
            wdata_d  = 32'd0;
            nbytes_d = 3'd4;
            state_d  = ST_READ;
          end
        end
      end

      ST_READ: begin
        if (pres_idx < nbytes_q) mem_a = pres_addr;
        if (own_q == OWN_IF && if_clear) begin
          state_d = ST_IDLE;
        end else if (rdy_in) begin
          pend_d = (pres_idx < nbytes_q);
          if (pend_q) begin
            rbuf_d = cap_word;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q + 3'd1 == nbytes_q) begin
              state_d = ST_DONE;
              if (own_q == OWN_LS) begin
                ls_done_d  = 1'b1;
                ls_rdata_d = cap_word;
              end else begin
                if_done_d = 1'b1;
                if_data_d = cap_word;
              end
            end
          end
        end else begin
          // in-flight byte is dropped; it is re-presented once rdy_in returns
          pend_d = 1'b0;
        end
      end

      ST_WRITE: begin
        mem_a    = pres_addr;
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy_in && !io_block;
        if (mem_wr) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q + 3'd1 == nbytes_q) begin
            state_d = ST_DONE;
            if (own_q == OWN_LS) ls_done_d = 1'b1;
            else                 if_done_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (rdy_in) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      own_q      <= OWN_IF;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      nbytes_q   <= 3'd0;
      cnt_q      <= 3'd0;
      pend_q     <= 1'b0;
      rbuf_q     <= 32'd0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nbytes_q   <= nbytes_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rbuf_q     <= rbuf_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_data_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of single accesses plus hand-written
// sequences for priority, I/O backpressure, stalls, fetch abort and mid-access reset.
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_clear;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // synchronous byte memory: address this cycle, data on mem_din next cycle
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h12;
      32'h0000_1002: return 8'h11;
      32'h0000_1003: return 8'h10;
      32'h0000_2006: return 8'h77;
      32'h0000_2007: return 8'h66;
      32'h0000_2009: return 8'h99;
      32'hFFFF_FFFF: return 8'hAB;
      32'h0000_0000: return 8'hCD;
      32'h0000_0102: return 8'h34;
      32'h0000_0103: return 8'h56;
      default:       return 8'hEE;
    endcase
  endfunction

  int          cyc = 0;
  int          wr_cnt = 0;
  int          if_pulses = 0;
  int          ls_pulses = 0;
  logic [7:0]  last_wr_d = 8'h00;

  always @(posedge clk_in) begin
    if (mem_wr) mem[mem_a] = mem_dout;
    mem_din <= mem.exists(mem_a) ? mem[mem_a] : init_byte(mem_a);
  end

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (mem_wr) begin
      wr_cnt    <= wr_cnt + 1;
      last_wr_d <= mem_dout;
    end
    if (if_done) if_pulses <= if_pulses + 1;
    if (ls_done) ls_pulses <= ls_pulses + 1;
  end

  int total = 0;
  int bad   = 0;
  int t_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, input bit want_ls, input int budget,
                           output int lat, output logic [31:0] data);
    lat  = -1;
    data = 32'd0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (want_ls ? ls_done : if_done) begin
        lat  = cyc - t_acc;
        data = want_ls ? ls_rdata : if_data;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done within %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          lat;
    logic [31:0] data;
    int          w0, p0, l0;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         32'h1011_1213, 5};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_1002, 32'h0,         32'h0000_0011, 2};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_1001, 32'h0,         32'h0000_1112, 3};
    vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h0000_1000, 32'h0,         32'h1011_1213, 5};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,         4};
    vecs[5]  = '{1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 5};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h0000_2004, 32'h1234_CAFE, 32'h0,         2};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_2004, 32'h0,         32'h6677_CAFE, 5};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_2008, 32'hFFFF_FF5A, 32'h0,         1};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'h0000_2008, 32'h0,         32'h0000_995A, 3};
    vecs[10] = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_CDAB, 3};

    rst_in = 1'b1; rdy_in = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; if_clear = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    io_buffer_full = 1'b0;

    #2;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_wr_dout", {23'd0, mem_wr, mem_dout}, 32'd0);
    chk("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk_in);
      if (vecs[i].is_if) begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end else begin
        ls_req = 1'b1; ls_we = vecs[i].we; ls_size = vecs[i].size;
        ls_addr = vecs[i].addr; ls_wdata = vecs[i].wdata;
      end
      t_acc = cyc + 1;
      wait_done($sformatf("vec%0d", i), !vecs[i].is_if, 20, lat, data);
      if_req = 1'b0; ls_req = 1'b0;
      if (lat >= 0) begin
        chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        if (!vecs[i].we) chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
        @(negedge clk_in);
        chk($sformatf("vec%0d_done_one_cycle", i), {30'd0, if_done, ls_done}, 32'd0);
      end
    end

    // LS wins over IF; IF accepted one idle cycle after ls_done
    @(negedge clk_in);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0000_1000;
    if_req = 1'b1; if_addr = 32'h0000_2000;
    t_acc = cyc + 1;
    @(negedge clk_in);
    chk("prio_first_addr", mem_a, 32'h0000_1000);
    wait_done("prio_ls", 1'b1, 20, lat, data);
    ls_req = 1'b0;
    chk("prio_ls_data", data, 32'h0000_0013);
    @(negedge clk_in);
    chk("prio_idle_gap", mem_a, 32'd0);
    t_acc = cyc + 1;
    @(negedge clk_in);
    chk("prio_if_addr", mem_a, 32'h0000_2000);
    wait_done("prio_if", 1'b0, 20, lat, data);
    if_req = 1'b0;
    chk("prio_if_data", data, 32'hDEAD_BEEF);
    chk("prio_if_latency", lat, 5);

    // I/O write held off by a full buffer for three cycles
    @(negedge clk_in);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_0041;
    io_buffer_full = 1'b1;
    w0 = wr_cnt;
    t_acc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk($sformatf("io_hold_wr%0d", i), {31'd0, mem_wr}, 32'd0);
    end
    @(posedge clk_in);
    #1 io_buffer_full = 1'b0;
    @(negedge clk_in);
    chk("io_write_now", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'h41});
    chk("io_write_addr", mem_a, 32'h0003_0000);
    wait_done("io_wr", 1'b1, 20, lat, data);
    ls_req = 1'b0;
    chk("io_wr_latency", lat, 4);
    chk("io_wr_count", wr_cnt - w0, 1);
    chk("io_wr_byte", {24'd0, last_wr_d}, 32'h0000_0041);

    // rdy_in low for the first two READ cycles of a half read
    @(negedge clk_in);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'h0000_0102;
    t_acc = cyc + 1;
    @(posedge clk_in);
    #1 rdy_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rdy_in = 1'b1;
    wait_done("stall_a", 1'b1, 20, lat, data);
    ls_req = 1'b0;
    chk("stall_a_data", data, 32'h0000_5634);
    chk("stall_a_latency", lat, 5);

    // rdy_in low on the edge that would capture byte 0
    @(negedge clk_in);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'h0000_0102;
    t_acc = cyc + 1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rdy_in = 1'b0;
    @(posedge clk_in);
    #1 rdy_in = 1'b1;
    wait_done("stall_b", 1'b1, 20, lat, data);
    ls_req = 1'b0;
    chk("stall_b_data", data, 32'h0000_5634);

    // if_clear in the third READ cycle aborts the fetch; pending LS follows
    @(negedge clk_in);
    if_req = 1'b1; if_addr = 32'h0000_1000;
    p0 = if_pulses;
    t_acc = cyc + 1;
    @(negedge clk_in);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0000_2008;
    @(negedge clk_in);
    @(negedge clk_in);
    if_clear = 1'b1;
    @(negedge clk_in);
    chk("clear_mem_a_zero", mem_a, 32'd0);
    if_clear = 1'b0; if_req = 1'b0;
    t_acc = cyc + 1;
    @(negedge clk_in);
    chk("clear_ls_addr", mem_a, 32'h0000_2008);
    wait_done("clear_ls", 1'b1, 20, lat, data);
    ls_req = 1'b0;
    chk("clear_ls_data", data, 32'h0000_005A);
    chk("clear_ls_latency", lat, 2);
    chk("clear_no_if_done", if_pulses - p0, 0);
    chk("clear_if_data_held", if_data, 32'hDEAD_BEEF);

    // reset in the middle of a word write
    @(negedge clk_in);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h0000_2010; ls_wdata = 32'h1122_3344;
    l0 = ls_pulses;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rstmid_writing", {31'd0, mem_wr}, 32'd1);
    rst_in = 1'b1;
    #1;
    chk("rstmid_mem_a", mem_a, 32'd0);
    chk("rstmid_wr_dout", {23'd0, mem_wr, mem_dout}, 32'd0);
    chk("rstmid_data", if_data | ls_rdata, 32'd0);
    chk("rstmid_dones", {30'd0, if_done, ls_done}, 32'd0);
    ls_req = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rstmid_no_ls_done", ls_pulses - l0, 0);
    rst_in = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0000_1000;
    t_acc = cyc + 1;
    @(negedge clk_in);
    chk("post_rst_accept", mem_a, 32'h0000_1000);
    wait_done("post_rst", 1'b1, 20, lat, data);
    ls_req = 1'b0;
    chk("post_rst_data", data, 32'h0000_0013);
    chk("post_rst_latency", lat, 2);
    repeat (3) @(negedge clk_in);
    chk("post_rst_pulses", ls_pulses - l0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_HI, default 2'b11: value of addr[17:16] that marks the I/O region.
REQ-002 SHALL have ports clk_in (in, 1, clock) and rst_in (in, 1, reset); reset is asynchronous and active-high.
REQ-003 SHALL have port rdy_in (in, 1): global pause; low freezes the controller.
REQ-004 SHALL have ports if_req (in, 1), if_addr (in, 32), if_clear (in, 1), if_done (out, 1), if_data (out, 32).
REQ-005 SHALL have ports ls_req (in, 1), ls_we (in, 1), ls_size (in, 2: 0 byte, 1 half, 2/3 word), ls_addr (in, 32), ls_wdata (in, 32), ls_done (out, 1), ls_rdata (out, 32).
REQ-006 SHALL have ports mem_din (in, 8), mem_dout (out, 8), mem_a (out, 32), mem_wr (out, 1), io_buffer_full (in, 1).

Function
REQ-007 SHALL be an FSM with states IDLE, READ, WRITE, DONE.
REQ-008 SHALL accept a request only in IDLE at an edge with rdy_in high.
REQ-009 SHALL give ls_req priority over if_req when both are high at that edge.
REQ-010 SHALL latch address, size, write data and owner at acceptance; the requester holds req and attributes until done.
REQ-011 SHALL set n = 4 for IF, n = 1/2/4 for LS sizes 0/1/2-3, with little-endian byte k at address addr+k (32-bit wrap).
REQ-012 READ SHALL present mem_a = addr+k in consecutive active cycles, k = 0..n-1, mem_wr = 0.
REQ-013 READ SHALL capture byte k from mem_din one cycle after its address is presented.
REQ-014 Read latency SHALL be: accept at edge t, last byte captured at edge t+n+1, done high between edges t+n+1 and t+n+2.
REQ-015 Read data SHALL be zero-extended above byte n-1; sign extension belongs to the requester.
REQ-016 WRITE SHALL drive mem_a = addr+k, mem_dout = byte k, mem_wr = 1 for one cycle per byte.
REQ-017 Write latency SHALL be: done high between edges t+n and t+n+1.
REQ-018 SHALL not issue an I/O-region write byte (addr+k bits[17:16] == IO_HI) while io_buffer_full is high: mem_wr = 0 and the byte is held until io_buffer_full is low.
REQ-019 SHALL pulse done (if_done or ls_done, per owner) for exactly one cycle, with if_data/ls_rdata valid that cycle and held until the next done.
REQ-020 DONE SHALL return to IDLE; no request is accepted at the edge ending the done cycle.
REQ-021 Outside an access, mem_a SHALL be 0 and mem_wr 0; no I/O address is presented speculatively.
REQ-022 rdy_in low SHALL freeze the state and byte index and force mem_wr = 0.
REQ-023 A byte whose address cycle or capture edge saw rdy_in low SHALL be discarded and re-presented after resume.
REQ-024 if_clear high at any edge SHALL abort an IF-owned READ (next state IDLE, no if_done, mem_a = 0) and block IF acceptance at that edge.
REQ-025 if_clear SHALL have no effect on LS-owned accesses.
REQ-026 if_clear coincident with the IF done edge SHALL suppress if_done.

Reset
REQ-027 rst_in high SHALL immediately force state IDLE and clear mem_a, mem_dout, mem_wr, if_done, ls_done, if_data, ls_rdata, byte index and owner.
REQ-028 Reset mid-access SHALL abandon the access with no done pulse.
REQ-029 The first acceptance SHALL be possible at the first rdy_in-high edge after rst_in falls.

Structure
REQ-030 State encodings, size codes and IO_HI SHALL live in the shared defines package used by the CPU.
REQ-031 The block SHALL be a single module with no sub-module.

Verification
REQ-032 IF word read of 0x00001000 holding bytes 13 12 11 10 -> if_data = 0x10111213, if_done high exactly 5 cycles after accept.
REQ-033 ls_req and if_req both high in IDLE -> LS served first; IF accepted 1 cycle after ls_done.
REQ-034 LS byte write 0x41 to 0x00030000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for 3 cycles, then one write of 0x41; ls_done the next cycle.
REQ-035 rdy_in low 2 cycles during a half read at 0x00000102 -> both bytes still correct; ls_rdata = 0x0000XXYY; done delayed 2 cycles.
REQ-036 if_clear asserted in the third READ cycle -> no if_done, mem_a = 0 next cycle, pending ls_req accepted the edge after that.
REQ-037 rst_in pulsed mid word-write -> all outputs 0 immediately and no ls_done.
